// File: rtl/field_packer_pkg.sv
// rtl/field_packer_pkg.sv - shared constants and output word record for field_packer
package field_packer_pkg;

  localparam int PK_N      = 64;
  localparam int PK_W      = 24;
  localparam int PK_ACC_W  = PK_N + PK_W;
  localparam int PK_FILL_W = $clog2(PK_ACC_W + 1);
  localparam int PK_LEN_W  = $clog2(PK_W + 1);
  localparam int PK_BITS_W = $clog2(PK_N + 1);

  typedef struct packed {
    logic [PK_N-1:0]      data;
    logic [PK_BITS_W-1:0] bits;
  } word_t;

endpackage

// File: rtl/field_packer_bit_append.sv
// rtl/field_packer_bit_append.sv - masks a field and ORs it into the left-aligned accumulator at offset fill
module field_packer_bit_append #(
  parameter int N      = 64,
  parameter int W      = 24,
  parameter int ACC_W  = N + W,
  parameter int FILL_W = $clog2(N + W + 1),
  parameter int LEN_W  = $clog2(W + 1)
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [FILL_W-1:0] fill,
  input  logic [W-1:0]      data,
  input  logic [LEN_W-1:0]  len,
  output logic [ACC_W-1:0]  acc_out
);

  logic [W-1:0]     mask;
  logic [W-1:0]     aligned;
  logic [ACC_W-1:0] placed;

  // Keep the low len bits, left-justify them, then drop them in just below the bits already held.
  // Relies on every accumulator bit at or below offset fill being zero.
  always_comb begin
    mask    = ~({W{1'b1}} << len);
    aligned = (data & mask) << (LEN_W'(W) - len);
    placed  = {aligned, {N{1'b0}}} >> fill;
    acc_out = acc_in | placed;
  end

endmodule

// File: rtl/field_packer.sv
// rtl/field_packer.sv - MSB-first variable-length field packer; PACKER_LEN_CHECK_EN adds sticky len_err
module field_packer
  import field_packer_pkg::*;
#(
  parameter int N = PK_N,
  parameter int W = PK_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     field_valid,
  input  logic [W-1:0]             field_data,
  input  logic [$clog2(W+1)-1:0]   field_len,
  output logic                     field_ready,
  input  logic                     flush,
  output logic                     word_valid,
  output logic [N-1:0]             word_data,
  output logic [$clog2(N+1)-1:0]   word_bits,
  input  logic                     word_ready
`ifdef PACKER_LEN_CHECK_EN
  ,
  output logic                     len_err
`endif
);

  localparam int ACC_W  = N + W;
  localparam int FILL_W = $clog2(N + W + 1);
  localparam int LEN_W  = $clog2(W + 1);
  localparam int BITS_W = $clog2(N + 1);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              flush_pend_q, flush_pend_d;
  logic              word_valid_q, word_valid_d;
  word_t             out_q, out_d;
  logic              len_err_q, len_err_d;

  logic              slot_free;
  logic              accept;
  logic              len_over;
  logic [LEN_W-1:0]  len_c;
  logic [FILL_W-1:0] sum;
  logic [ACC_W-1:0]  appended;

  field_packer_bit_append #(
    .N      (N),
    .W      (W),
    .ACC_W  (ACC_W),
    .FILL_W (FILL_W),
    .LEN_W  (LEN_W)
  ) u_bit_append (
    .acc_in  (acc_q),
    .fill    (fill_q),
    .data    (field_data),
    .len     (len_c),
    .acc_out (appended)
  );

  // Handshake qualifiers, length clamp and the fill position after this field.
  always_comb begin
    slot_free   = !word_valid_q || word_ready;
    field_ready = !rst && !flush_pend_q && slot_free;
    accept      = field_valid && field_ready;
    len_over    = field_len > LEN_W'(W);
    len_c       = len_over ? LEN_W'(W) : field_len;
    sum         = fill_q + FILL_W'(len_c);
  end

  // Next-state: accept a field (possibly completing a word) or execute a pending flush.
  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    word_valid_d = word_valid_q && !word_ready;
    out_d        = out_q;
    len_err_d    = len_err_q;

    if (accept) begin
      if (sum >= FILL_W'(N)) begin
        out_d.data   = appended[ACC_W-1 -: N];
        out_d.bits   = BITS_W'(N);
        word_valid_d = 1'b1;
        acc_d        = appended << N;
        fill_d       = sum - FILL_W'(N);
      end else begin
        acc_d  = appended;
        fill_d = sum;
      end
      // A flush arriving with the field applies after it, so it includes this field.
      if (flush) begin
        flush_pend_d = 1'b1;
      end
      if (len_over) begin
        len_err_d = 1'b1;
      end
    end else if (flush_pend_q && slot_free) begin
      if (fill_q != '0) begin
        out_d.data   = acc_q[ACC_W-1 -: N];
        out_d.bits   = BITS_W'(fill_q);
        word_valid_d = 1'b1;
      end
      acc_d        = '0;
      fill_d       = '0;
      flush_pend_d = 1'b0;
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end
  end

  // State registers; reset drops partial bits, the held word and any pending flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      word_valid_q <= 1'b0;
      out_q        <= '0;
      len_err_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      word_valid_q <= word_valid_d;
      out_q        <= out_d;
      len_err_q    <= len_err_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = out_q.data;
  assign word_bits  = out_q.bits;

`ifdef PACKER_LEN_CHECK_EN
  assign len_err = len_err_q;
`else
  logic unused_len_err;
  assign unused_len_err = len_err_q;
`endif

endmodule

// File: tb/tb_field_packer.sv
// tb/tb_field_packer.sv - scoreboard bench for field_packer with directed field vectors
module tb_field_packer;
  import field_packer_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 field_valid;
  logic [PK_W-1:0]      field_data;
  logic [PK_LEN_W-1:0]  field_len;
  logic                 field_ready;
  logic                 flush;
  logic                 word_valid;
  logic [PK_N-1:0]      word_data;
  logic [PK_BITS_W-1:0] word_bits;
  logic                 word_ready;
`ifdef PACKER_LEN_CHECK_EN
  logic                 len_err;
`endif

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    t0;
  word_t exp_q[$];
  word_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  field_packer dut (
    .clk         (clk),
    .rst         (rst),
    .field_valid (field_valid),
    .field_data  (field_data),
    .field_len   (field_len),
    .field_ready (field_ready),
    .flush       (flush),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_bits   (word_bits),
    .word_ready  (word_ready)
`ifdef PACKER_LEN_CHECK_EN
    ,
    .len_err     (len_err)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [63:0] d, input int b);
    word_t e;
    e.data = d;
    e.bits = PK_BITS_W'(b);
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [23:0] d, input logic [4:0] l, input logic fl);
    int n;
    field_valid = 1'b1;
    field_data  = d;
    field_len   = l;
    flush       = fl;
    n = 0;
    @(negedge clk);
    while (!field_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!field_ready) check("push_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    field_valid = 1'b0;
    field_data  = '0;
    field_len   = '0;
    flush       = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed word is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h/%0d required=none", word_data, word_bits);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_data", word_data, mon_e.data);
        check("word_bits", 64'(word_bits), 64'(mon_e.bits));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; field_valid = 1'b0; field_data = '0; field_len = '0;
    flush = 1'b0; word_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_word_valid", 64'(word_valid), 64'd0);
    check("rst_word_data", word_data, 64'd0);
    check("rst_word_bits", 64'(word_bits), 64'd0);
    check("rst_field_ready", 64'(field_ready), 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // three full fields -> one word, residual 0xBC
    expect_word(64'hABCDEF123456789A, 64);
    push(24'hABCDEF, 5'd24, 1'b0);
    push(24'h123456, 5'd24, 1'b0);
    push(24'h789ABC, 5'd24, 1'b0);
    check("latency_valid", 64'(word_valid), 64'd1);
    expect_word(64'hBC00000000000000, 8);
    pulse_flush();
    check("flush_blocks_ready", 64'(field_ready), 64'd0);
    @(posedge clk); #1;
    check("ready_after_flush", 64'(field_ready), 64'd1);
    check("partial_valid", 64'(word_valid), 64'd1);
    idle(2);

    // backpressure: held word blocks fields and stays stable
    word_ready = 1'b0;
    expect_word(64'h1111112222223333, 64);
    push(24'h111111, 5'd24, 1'b0);
    push(24'h222222, 5'd24, 1'b0);
    push(24'h333333, 5'd24, 1'b0);
    field_valid = 1'b1; field_data = 24'h444444; field_len = 5'd24;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_field_ready", 64'(field_ready), 64'd0);
      check("bp_word_data", word_data, 64'h1111112222223333);
    end
    @(posedge clk); #1;
    word_ready = 1'b1;
    expect_word(64'h3344444455555566, 64);
    t0 = cyc;
    push(24'h444444, 5'd24, 1'b0);
    push(24'h555555, 5'd24, 1'b0);
    push(24'h666666, 5'd24, 1'b0);
    check("stream_cycles", 64'(cyc - t0), 64'd3);
    expect_word(64'h6666000000000000, 16);
    pulse_flush();
    idle(3);

    // zero length, then oversize length clamped to 24
    push(24'hFFFFFF, 5'd0, 1'b0);
`ifdef PACKER_LEN_CHECK_EN
    check("len_err_clear", 64'(len_err), 64'd0);
`endif
    push(24'hFFFFFF, 5'd30, 1'b0);
    expect_word(64'hFFFFFF0000000000, 24);
    pulse_flush();
    idle(3);
`ifdef PACKER_LEN_CHECK_EN
    check("len_err_sticky", 64'(len_err), 64'd1);
`endif

    // flush with nothing buffered emits no word
    pulse_flush();
    check("empty_flush_pending", 64'(field_ready), 64'd0);
    @(posedge clk); #1;
    check("empty_flush_ready", 64'(field_ready), 64'd1);
    check("empty_flush_no_word", 64'(word_valid), 64'd0);
    idle(2);

    // completing field plus flush: full word then partial, no gap
    expect_word(64'h123456789ABCDEF0, 64);
    expect_word(64'h1200000000000000, 8);
    push(24'h123456, 5'd24, 1'b0);
    push(24'h789ABC, 5'd24, 1'b0);
    push(24'hDEF012, 5'd24, 1'b1);
    check("full_first_valid", 64'(word_valid), 64'd1);
    @(posedge clk); #1;
    check("partial_after_full", 64'(word_valid), 64'd1);
    idle(3);

    // reset mid-operation with a word held and bits buffered
    word_ready = 1'b0;
    push(24'hAAAAAA, 5'd24, 1'b0);
    push(24'hBBBBBB, 5'd24, 1'b0);
    push(24'hCCCCCC, 5'd24, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 64'(word_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_word_valid", 64'(word_valid), 64'd0);
    check("mid_rst_word_data", word_data, 64'd0);
    check("mid_rst_word_bits", 64'(word_bits), 64'd0);
    check("mid_rst_field_ready", 64'(field_ready), 64'd0);
`ifdef PACKER_LEN_CHECK_EN
    check("mid_rst_len_err", 64'(len_err), 64'd0);
`endif
    rst = 1'b0;
    word_ready = 1'b1;
    expect_word(64'h0102030405060708, 64);
    expect_word(64'h0900000000000000, 8);
    push(24'h010203, 5'd24, 1'b0);
    push(24'h040506, 5'd24, 1'b0);
    push(24'h070809, 5'd24, 1'b0);
    pulse_flush();
    idle(4);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
